// File: rtl/mips_mem_pkg.sv
// Shared constants for the instruction/data backing-memory arbiter:
// FSM state encoding, round-robin grant identifiers and default burst length.
package mips_mem_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] I_BURST  = 2'd1;
  localparam logic [1:0] D_ACCESS = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int DEFAULT_BLOCK_WORDS = 4;

endpackage

// File: rtl/burst_counter.sv
// Beat counter for I-side refill bursts: current beat index, last-beat
// detection and the byte address of the following beat.
module burst_counter
  import mips_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
  parameter int ADDR_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           advance,
  input  logic [ADDR_W-1:0]              cur_addr,
  output logic [$clog2(BLOCK_WORDS)-1:0] idx,
  output logic                           last,
  output logic [ADDR_W-1:0]              next_addr
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  assign last      = (idx == LAST_IDX);
  assign next_addr = cur_addr + ADDR_W'(4);

  // Wraps to zero on the final beat so the next burst starts at beat 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (advance) begin
      idx <= last ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between the I-cache
// refill engine (block bursts) and the data-memory path (single words).
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_req,
  input  logic [ADDR_W-1:0]              i_addr,
  output logic [DATA_W-1:0]              i_rdata,
  output logic                           i_rvalid,
  output logic [$clog2(BLOCK_WORDS)-1:0] i_word_idx,
  output logic                           i_done,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic [DATA_W-1:0]              d_wdata,
  output logic [DATA_W-1:0]              d_rdata,
  output logic                           d_done,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_ack,
  output logic                           stall,
  output logic [1:0]                     state
);

  logic              last_grant;
  logic              beat_last;
  logic              ack_ok;
  logic              grant_i;
  logic              grant_d;
  logic [ADDR_W-1:0] next_addr;

  // Memory handshake: mem_req/mem_we/mem_addr/mem_wdata form a held request
  // that stays unchanged until a cycle with mem_req=1 and mem_ack=1; that
  // cycle is the beat transfer, and mem_ack in any other cycle is ignored.
  assign ack_ok = mem_req & mem_ack;

  assign i_rvalid = (state == I_BURST) & ack_ok;
  assign i_done   = i_rvalid & beat_last;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;

  assign d_done   = (state == D_ACCESS) & ack_ok;
  assign d_rdata  = d_done ? mem_rdata : '0;

  assign stall = ~reset & ((i_req & ~i_done) | (d_req & ~d_done));

  // On a tie, the side that did not win last time goes first.
  assign grant_i = i_req & (~d_req | (last_grant == GRANT_D));
  assign grant_d = d_req & ~grant_i;

  burst_counter #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_burst_counter (
    .clk      (clk),
    .rst      (reset),
    .advance  (i_rvalid),
    .cur_addr (mem_addr),
    .idx      (i_word_idx),
    .last     (beat_last),
    .next_addr(next_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state      <= I_BURST;
            last_grant <= GRANT_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= i_addr;
          end else if (grant_d) begin
            state      <= D_ACCESS;
            last_grant <= GRANT_D;
            mem_req    <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
          end
        end
        I_BURST: begin
          if (ack_ok) begin
            if (beat_last) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end else begin
              mem_addr <= next_addr;
            end
          end
        end
        D_ACCESS: begin
          if (ack_ok) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model of owner/beat/round-robin,
// a bench-side memory responder, directed scenarios and a random soak.
module tb_mem_arbiter;

  localparam int BW = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_rvalid;
  logic [1:0]    i_word_idx;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall;
  logic [1:0]    state;

  mem_arbiter #(
    .BLOCK_WORDS(BW),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_rvalid  (i_rvalid),
    .i_word_idx(i_word_idx),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .state     (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;

  int            m_owner;      // 0 none, 1 I burst, 2 D access
  int            m_beat;       // beats already delivered in current burst
  logic [AW-1:0] m_base;
  logic          m_we_cap;
  logic [DW-1:0] m_wd_cap;
  bit            m_last_d;     // last grant went to D
  int            m_wait;
  bit            exp_i_done_c;
  bit            exp_d_done_c;

  int            fixed_lat;
  bit            spurious_en;
  bit            auto_i;
  bit            auto_d;
  bit            force_rd;
  logic [DW-1:0] force_rd_val;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] beat_addr_q[$];
  int            beat_idx_q[$];
  int            grant_q[$];
  int            exp_int_q[$];
  logic [1:0]    prev_state;
  int            i_rvalid_cnt;
  int            d_done_cnt;
  int            stall_low_cnt;
  logic          stall_at_idone;
  logic [DW-1:0] d_rdata_seen;
  logic          we_at_ddone;
  logic [AW-1:0] addr_at_ddone;
  logic [DW-1:0] wdata_at_ddone;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_lat();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    m_owner      = 0;
    m_beat       = 0;
    m_last_d     = 1'b1;
    m_wait       = 0;
    exp_i_done_c = 1'b0;
    exp_d_done_c = 1'b0;
    prev_state   = 2'd0;
  endtask

  task automatic clear_rec();
    beat_addr_q.delete();
    beat_idx_q.delete();
    grant_q.delete();
    i_rvalid_cnt   = 0;
    d_done_cnt     = 0;
    stall_low_cnt  = 0;
    stall_at_idone = 1'bx;
    d_rdata_seen   = '0;
  endtask

  // Compare every DUT output against the model; runs mid-cycle (negedge).
  task automatic check_cycle();
    bit            e_irv;
    bit            e_idone;
    bit            e_ddone;
    bit            e_stall;
    logic [AW-1:0] ea;
    e_irv   = (m_owner == 1) && mem_ack;
    e_idone = e_irv && (m_beat == BW - 1);
    e_ddone = (m_owner == 2) && mem_ack;
    e_stall = (i_req && !e_idone) || (d_req && !e_ddone);
    chk("state", state, m_owner);
    chk("mem_req", mem_req, m_owner != 0);
    if (m_owner == 1) begin
      ea = m_base + AW'(4 * m_beat);
      chk("i_mem_addr", mem_addr, ea);
      chk("i_mem_we", mem_we, 0);
    end
    if (m_owner == 2) begin
      chk("d_mem_addr", mem_addr, m_base);
      chk("d_mem_we", mem_we, m_we_cap);
      if (m_we_cap) chk("d_mem_wdata", mem_wdata, m_wd_cap);
    end
    chk("i_rvalid", i_rvalid, e_irv);
    chk("i_done", i_done, e_idone);
    chk("i_rdata", i_rdata, e_irv ? mem_rdata : '0);
    chk("i_word_idx", i_word_idx, (m_owner == 1) ? m_beat : 0);
    chk("d_done", d_done, e_ddone);
    chk("d_rdata", d_rdata, e_ddone ? mem_rdata : '0);
    chk("stall", stall, e_stall);
    if (i_rvalid) begin
      beat_addr_q.push_back(mem_addr);
      beat_idx_q.push_back(int'(i_word_idx));
      i_rvalid_cnt++;
    end
    if (i_done) stall_at_idone = stall;
    if (d_done) begin
      d_done_cnt++;
      d_rdata_seen   = d_rdata;
      we_at_ddone    = mem_we;
      addr_at_ddone  = mem_addr;
      wdata_at_ddone = mem_wdata;
    end
    if (i_req && d_req && !stall) stall_low_cnt++;
    if (state != prev_state && state != 2'd0) grant_q.push_back(int'(state));
    prev_state   = state;
    exp_i_done_c = e_idone;
    exp_d_done_c = e_ddone;
  endtask

  // Advance the model across a rising edge using the inputs held at that edge.
  task automatic model_update();
    if (m_owner == 0) begin
      if (i_req && (!d_req || m_last_d)) begin
        m_owner  = 1;
        m_base   = i_addr;
        m_beat   = 0;
        m_last_d = 1'b0;
        m_wait   = next_lat();
      end else if (d_req) begin
        m_owner  = 2;
        m_base   = d_addr;
        m_we_cap = d_we;
        m_wd_cap = d_wdata;
        m_last_d = 1'b1;
        m_wait   = next_lat();
      end
    end else if (mem_ack) begin
      if (m_owner == 1) begin
        m_beat++;
        if (m_beat == BW) begin
          m_owner = 0;
          m_beat  = 0;
        end
      end else begin
        m_owner = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    if (exp_i_done_c) i_req = 1'b0;
    if (exp_d_done_c) d_req = 1'b0;
    if (auto_i && !i_req && $urandom_range(0, 3) == 0) begin
      i_req  = 1'b1;
      i_addr = $urandom & ~(32'(BW * 4 - 1));
    end
    if (auto_d && !d_req && $urandom_range(0, 3) == 0) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom & ~32'h3;
      d_wdata = $urandom;
    end
    mem_rdata = force_rd ? force_rd_val : $urandom;
    if (m_owner != 0) begin
      if (m_wait == 0) begin
        mem_ack = 1'b1;
        m_wait  = next_lat();
      end else begin
        mem_ack = 1'b0;
        m_wait--;
      end
    end else begin
      mem_ack = spurious_en && ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_update();
    #1;
    drive();
  endtask

  task automatic run_drain(int max_cycles);
    int n = 0;
    while ((i_req || d_req || m_owner != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    chk("drain_bound", n < max_cycles, 1);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    reset   = 1'b1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_addr_seq(string name);
    chk(name, beat_addr_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < beat_addr_q.size(); k++)
      chk(name, beat_addr_q[k], exp_q[k]);
  endtask

  task automatic chk_int_seq(string name, bit use_grants);
    int got[$];
    got = use_grants ? grant_q : beat_idx_q;
    chk(name, got.size(), exp_int_q.size());
    for (int k = 0; k < exp_int_q.size() && k < got.size(); k++)
      chk(name, got[k], exp_int_q[k]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    fixed_lat = 1; spurious_en = 1'b0; auto_i = 1'b0; auto_d = 1'b0;
    force_rd = 1'b0; force_rd_val = '0;
    model_reset();
    clear_rec();

    // Reset asserted before any clock edge; stall must stay low even with a request.
    #1 reset = 1'b1;
    #1 i_req = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_state", state, 0);
    chk("rst_word_idx", i_word_idx, 0);
    chk("rst_stall", stall, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_done", d_done, 0);
    i_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Burst at 0x100, ack every second cycle.
    clear_rec();
    fixed_lat = 1; i_addr = 32'h100; i_req = 1'b1;
    run_drain(100);
    exp_q.delete();
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    exp_q.push_back(32'h108); exp_q.push_back(32'h10C);
    chk_addr_seq("t1_beat_addr");
    exp_int_q.delete();
    exp_int_q.push_back(0); exp_int_q.push_back(1);
    exp_int_q.push_back(2); exp_int_q.push_back(3);
    chk_int_seq("t1_word_idx", 1'b0);
    chk("t1_rvalid_cnt", i_rvalid_cnt, 4);
    chk("t1_stall_at_done", stall_at_idone, 0);

    // Single write, ack after three wait cycles.
    clear_rec();
    fixed_lat = 3; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    run_drain(100);
    chk("t2_d_done_cnt", d_done_cnt, 1);
    chk("t2_mem_we", we_at_ddone, 1);
    chk("t2_mem_addr", addr_at_ddone, 32'h2000);
    chk("t2_mem_wdata", wdata_at_ddone, 32'hDEADBEEF);
    chk("t2_state_idle", state, 0);

    // Simultaneous pairs after reset: I, D, I, D.
    apply_reset();
    clear_rec();
    fixed_lat = 0;
    i_addr = 32'h400; d_we = 1'b0; d_addr = 32'h500; i_req = 1'b1; d_req = 1'b1;
    run_drain(200);
    i_addr = 32'h800; d_we = 1'b1; d_addr = 32'h900; d_wdata = 32'h55AA; i_req = 1'b1; d_req = 1'b1;
    run_drain(200);
    exp_int_q.delete();
    exp_int_q.push_back(1); exp_int_q.push_back(2);
    exp_int_q.push_back(1); exp_int_q.push_back(2);
    chk_int_seq("t3_grant_order", 1'b1);

    // D request arriving mid-burst waits for the whole burst.
    clear_rec();
    fixed_lat = 1; i_addr = 32'h40; i_req = 1'b1;
    cycle(); cycle(); cycle();
    d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
    run_drain(200);
    exp_int_q.delete();
    exp_int_q.push_back(1); exp_int_q.push_back(2);
    chk_int_seq("t4_grant_order", 1'b1);
    exp_q.delete();
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    exp_q.push_back(32'h48); exp_q.push_back(32'h4C);
    chk_addr_seq("t4_beat_addr");
    chk("t4_stall_low", stall_low_cnt, 0);

    // Reset during beat 2, then a stray ack, then a fresh burst.
    clear_rec();
    fixed_lat = 1; i_addr = 32'h200; i_req = 1'b1;
    n = 0;
    while (m_beat != 2 && n < 50) begin
      cycle();
      n++;
    end
    chk("t5_reach_beat2", n < 50, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_mem_req", mem_req, 0);
    chk("t5_async_state", state, 0);
    chk("t5_async_word_idx", i_word_idx, 0);
    chk("t5_async_stall", stall, 0);
    i_req = 1'b0;
    model_reset();
    mem_ack = 1'b1;
    #1;
    chk("t5_ack_in_reset", i_rvalid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_rec();
    mem_ack = 1'b1;
    cycle();
    chk("t5_late_ack_rvalid", i_rvalid_cnt, 0);
    i_addr = 32'h300; i_req = 1'b1;
    run_drain(100);
    exp_int_q.delete();
    exp_int_q.push_back(0); exp_int_q.push_back(1);
    exp_int_q.push_back(2); exp_int_q.push_back(3);
    chk_int_seq("t5_restart_idx", 1'b0);

    // Read at 0x3FC returns the memory word.
    clear_rec();
    fixed_lat = 2; force_rd = 1'b1; force_rd_val = 32'h12345678;
    d_we = 1'b0; d_addr = 32'h3FC; d_req = 1'b1;
    run_drain(100);
    force_rd = 1'b0;
    chk("t6_d_rdata", d_rdata_seen, 32'h12345678);
    chk("t6_d_done_cnt", d_done_cnt, 1);
    chk("t6_mem_addr", addr_at_ddone, 32'h3FC);

    // Random soak: both requesters, random latency, stray acks while idle.
    clear_rec();
    fixed_lat = -1; spurious_en = 1'b1; auto_i = 1'b1; auto_d = 1'b1;
    for (int k = 0; k < 2000; k++) cycle();
    auto_i = 1'b0; auto_d = 1'b0;
    run_drain(300);
    spurious_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified backing-memory port between two requesters:
  - the fetch-stage instruction-cache refill engine, which issues block bursts after a miss (hit=0);
  - the data_memory miss/uncached path, which issues single-word reads and writes.
- Sits between the fetch/data-memory units and external memory.
- Produces a pipeline stall while any requester is waiting or in service.
- Arbitrates round-robin when both sides request together; a granted transaction always runs to completion.

Parameters:
- BLOCK_WORDS, 4, words per I-side refill burst; power of two, 2..16.
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  I refill request; held until i_done
- i_addr  in  ADDR_W  block-aligned byte address; stable while i_req=1
- i_rdata  out  DATA_W  refill word, valid when i_rvalid=1
- i_rvalid  out  1  one beat delivered this cycle
- i_word_idx  out  log2(BLOCK_WORDS)  index of the current beat
- i_done  out  1  last beat of the burst (coincides with the final i_rvalid)
- d_req  in  1  D request; held until d_done
- d_we  in  1  1=write, 0=read; stable while d_req=1
- d_addr  in  ADDR_W  word-aligned byte address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid when d_done=1 and d_we=0
- d_done  out  1  D access complete
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse per beat
- stall  out  1  freeze the pipeline

Behaviour:
- States:
  - IDLE
  - I_BURST
  - D_ACCESS
- Reset (asynchronous, any time, including mid-burst):
  - State goes to IDLE; beat counter = 0; last_grant = D (so the first tie goes to I).
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - Any memory transaction in flight is abandoned; a mem_ack arriving after reset is ignored.
- IDLE:
  - Only d_req=1: go to D_ACCESS. Only i_req=1: go to I_BURST.
  - Both set: grant the side opposite last_grant, then update last_grant.
  - Grant latency is 1 cycle: request sampled at edge N, mem_req=1 from edge N.
  - On entering I_BURST: mem_addr = i_addr, mem_we = 0.
  - On entering D_ACCESS: mem_addr = d_addr, mem_we = d_we, mem_wdata = d_wdata.
- Memory handshake:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack=1.
  - mem_ack is ignored outside I_BURST and D_ACCESS, and ignored when mem_req=0.
  - Memory latency is unbounded; there is no timeout.
- I_BURST:
  - On each mem_ack: i_rvalid=1 and i_rdata=mem_rdata, combinational pass-through in the same cycle; i_word_idx = beat counter.
  - At the edge after the ack: counter increments and mem_addr = i_addr + 4*(counter+1) (ADDR_W modulo); mem_req stays 1.
  - On the ack with counter = BLOCK_WORDS-1: i_done=1; at the next edge mem_req=0, counter = 0, state = IDLE.
- D_ACCESS:
  - On mem_ack: d_done=1 and d_rdata=mem_rdata, same cycle; at the next edge mem_req=0 and state = IDLE.
  - For writes, d_rdata is don't-care and is driven as mem_rdata.
- Requester rule:
  - A requester deasserts req at the edge ending its done cycle, so IDLE never re-grants a finished request.
  - If req falls mid-transaction, the arbiter still completes it and discards the results (i_rvalid/d_done still pulse).
- Back-to-back:
  - Minimum 1 IDLE cycle between transactions.
  - A pending requester that lost the tie is granted at the following IDLE cycle.
- stall = (i_req & ~i_done) | (d_req & ~d_done), combinational:
  - deasserts in the final beat cycle;
  - 0 in reset.
- Default outputs whenever not otherwise driven: i_rvalid, i_done, d_done = 0; i_rdata, d_rdata = 0.

Decomposition:
- Shared package mips_mem_pkg holds:
  - state encoding: IDLE=2'd0, I_BURST=2'd1, D_ACCESS=2'd2;
  - GRANT_I / GRANT_D constants;
  - the default BLOCK_WORDS.
- One natural sub-module, burst_counter: beat index, wrap detection and address increment.
- The FSM, the round-robin bit and the output registers stay in mem_arbiter.

Test Plan:
- Reset released, then i_req=1 with i_addr=0x100, memory acks every 2nd cycle:
  - mem_addr sequence 0x100, 0x104, 0x108, 0x10C;
  - 4 i_rvalid pulses with i_word_idx 0..3;
  - i_done on the 4th beat; stall falls in that cycle.
- d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, ack after 3 cycles:
  - mem_we=1 with stable address and data until the ack;
  - d_done pulses once; state returns to IDLE.
- i_req and d_req rise in the same cycle after reset:
  - I is granted first (last_grant reset = D);
  - D is granted in the IDLE cycle after i_done;
  - a second simultaneous request pair is granted to I again, per the round-robin toggle.
- d_req raised mid-burst:
  - the burst completes all 4 beats uninterrupted;
  - D is then serviced; stall stays 1 throughout.
- reset pulsed during beat 2 of a burst:
  - mem_req=0 and state = IDLE immediately, without waiting for a clock edge;
  - a late mem_ack produces no i_rvalid;
  - a new i_req restarts from i_word_idx=0.
- d_req read at d_addr=0x3FC with mem_rdata=0x12345678: d_rdata=0x12345678 in the d_done cycle, with i_req held 0.
